// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: accepts a block, steps rounds 0..10 through the
// external round datapath, then holds the result until it is taken. Option macro: AES_ROUND_CTRL_BACK2BACK_EN.
module aes_round_ctrl #(
  parameter int unsigned NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic [3:0]   round,
  output logic         sub_en,
  output logic         mix_en,
  output logic [127:0] dp_state,
  input  logic [127:0] dp_result,
  output logic         busy,
  output logic         abort
);

  localparam logic [3:0] LAST = 4'(NROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  st_t          st_q, st_d;
  logic [127:0] state_q;
  logic [3:0]   rcnt_q;
  logic         abort_q;
  logic         accept;

  assign accept    = in_valid & in_ready;
  assign dp_state  = state_q;
  assign out_block = state_q;
  assign abort     = abort_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      abort_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      abort_q <= (st_q == RUN) & ~key_valid;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: if (accept) st_d = RUN;
      RUN: begin
        if (!key_valid)          st_d = IDLE;
        else if (rcnt_q == LAST) st_d = DONE;
      end
      // accept can only be high here when back-to-back loading is compiled in
      DONE: if (out_ready) st_d = accept ? RUN : IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    round     = '0;
    sub_en    = 1'b0;
    mix_en    = 1'b0;
    busy      = 1'b0;
    unique case (st_q)
      IDLE: in_ready = key_valid & ~rst;
      RUN: begin
        busy   = 1'b1;
        round  = rcnt_q;
        sub_en = (rcnt_q != '0);
        mix_en = (rcnt_q != '0) & (rcnt_q != LAST);
      end
      DONE: begin
        out_valid = 1'b1;
`ifdef AES_ROUND_CTRL_BACK2BACK_EN
        in_ready  = out_ready & key_valid & ~rst;
`else
        in_ready  = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // A RUN cycle with key_valid low leaves state_q and rcnt untouched (abort path).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      rcnt_q  <= '0;
    end else if (accept) begin
      state_q <= in_block;
      rcnt_q  <= '0;
    end else if (st_q == RUN && key_valid) begin
      state_q <= dp_result;
      if (rcnt_q != LAST) rcnt_q <= rcnt_q + 4'd1;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: behavioural AES round datapath, directed steps,
// and a scoreboard of expected ciphertexts pushed on accept and popped on output.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst, key_valid, in_valid, out_ready;
  logic         in_ready, out_valid, sub_en, mix_en, busy, abort;
  logic [127:0] in_block, out_block, dp_state, dp_result;
  logic [3:0]   round;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_ROUND_CTRL_BACK2BACK_EN
  localparam int   SPACING   = 12;
  localparam logic IRDY_DONE = 1'b1;
`else
  localparam int   SPACING   = 13;
  localparam logic IRDY_DONE = 1'b0;
`endif

  typedef struct {logic [127:0] d; int t;} sb_t;
  sb_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic ov_prev = 1'b0;
  logic [127:0] rk [16];

  aes_round_ctrl #(.NROUNDS(10)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .round(round), .sub_en(sub_en), .mix_en(mix_en), .dp_state(dp_state),
    .dp_result(dp_result), .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(logic [7:0] x);
    logic [7:0] r = 8'h01, b = x, e = 8'hfe;
    for (int unsigned i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, b);
      b = gmul(b, b);
    end
    if (x == 8'h00) r = 8'h00;
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] dp_model(logic [127:0] s, logic [127:0] k, logic sub, logic mix);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int unsigned i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    if (sub) begin
      for (int unsigned i = 0; i < 16; i++) t[i] = sbox(b[i]);
      for (int unsigned r = 0; r < 4; r++)
        for (int unsigned c = 0; c < 4; c++) b[r+4*c] = t[r+4*((c+r)%4)];
    end
    if (mix) begin
      for (int unsigned c = 0; c < 4; c++) begin
        logic [7:0] a0, a1, a2, a3;
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        b[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        b[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        b[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int unsigned i = 0; i < 16; i++) o[127-8*i -: 8] = b[i] ^ k[127-8*i -: 8];
    return o;
  endfunction

  function automatic logic [127:0] aes_part(logic [127:0] blk, int unsigned n);
    logic [127:0] s = blk;
    for (int unsigned r = 0; r < n; r++) s = dp_model(s, rk[r], r != 0, r != 0 && r != 10);
    return s;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int unsigned i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int unsigned i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int unsigned r = 0; r < 16; r++)
      rk[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Datapath driven purely by the controller's round/sub_en/mix_en outputs
  always_comb dp_result = dp_model(dp_state, rk[round], sub_en, mix_en);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_block"}, out_block, 0);
    chk({tag, "_dp_state"}, dp_state, 0);
    chk({tag, "_round"}, round, 0);
    chk({tag, "_sub_en"}, sub_en, 0);
    chk({tag, "_mix_en"}, mix_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_abort"}, abort, 0);
  endtask

  always @(negedge clk) begin
    if (in_valid && in_ready) sb.push_back('{aes_part(in_block, 11), cyc});
    if (abort) begin
      chk("abort_pending", sb.size() != 0, 1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    if (out_valid && !ov_prev) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) chk("latency", cyc - sb[0].t, 12);
    end
    if (out_valid && out_ready && sb.size() != 0) begin
      chk("sb_out_block", out_block, sb[0].d);
      void'(sb.pop_front());
    end
    ov_prev = out_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] blk;
    int acc [4];
    int n;

    rst = 1'b1; key_valid = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_block = '0;
    expand(KEY);
    tick(); tick();
    check_reset("reset");
    rst = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 1);

    // FIPS-197 vector, round/enable sequence
    in_block = PT; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int unsigned r = 0; r <= 10; r++) begin
      chk("run_round", round, r);
      chk("run_sub_en", sub_en, r != 0);
      chk("run_mix_en", mix_en, r != 0 && r != 10);
      chk("run_busy", busy, 1);
      chk("run_out_valid", out_valid, 0);
      chk("run_in_ready", in_ready, 0);
      tick();
    end
    chk("fips_out_valid", out_valid, 1);
    chk("fips_out_block", out_block, CT);
    chk("done_busy", busy, 0);
    chk("done_round", round, 0);

    // Backpressure
    repeat (20) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_block", out_block, CT);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("done_in_ready_or", in_ready, IRDY_DONE);
    tick();
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    out_ready = 1'b0;

    // key_valid low in IDLE, then abort at round 5
    blk = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b0; in_valid = 1'b1; in_block = blk;
    #1;
    chk("nokey_in_ready", in_ready, 0);
    tick();
    chk("nokey_busy", busy, 0);
    key_valid = 1'b1;
    #1;
    chk("key_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("abort_round5", round, 5);
    key_valid = 1'b0;
    tick();
    chk("abort_pulse", abort, 1);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_state", dp_state, aes_part(blk, 5));
    key_valid = 1'b1;
    tick();
    chk("abort_one_cycle", abort, 0);
    repeat (14) begin
      chk("abort_no_out", out_valid, 0);
      tick();
    end

    // Reset mid-RUN at round 7
    in_block = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("rst_round7", round, 7);
    rst = 1'b1;
    tick();
    check_reset("midrun_rst");
    sb.delete();
    rst = 1'b0;
    tick();
    chk("post_rst_abort", abort, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // Four blocks with in_valid and out_ready held high
    out_ready = 1'b1; in_valid = 1'b1; n = 0;
    in_block = {$urandom, $urandom, $urandom, $urandom};
    for (int unsigned k = 0; k < 120 && n < 4; k++) begin
      if (in_ready) begin
        acc[n] = cyc;
        n++;
        tick();
        in_block = {$urandom, $urandom, $urandom, $urandom};
        if (n == 4) in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    chk("b2b_accepts", n, 4);
    for (int i = 1; i < n; i++) chk("b2b_spacing", acc[i] - acc[i-1], SPACING);
    for (int unsigned k = 0; k < 40 && sb.size() != 0; k++) tick();
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 round sequencer. Accepts one 128-bit block through a valid/ready handshake, runs rounds 0..10 through the shared round datapath (SubBytes/ShiftRows/MixColumns followed by round-key XOR), and presents the ciphertext block through a valid/ready output with backpressure. It sits between the CTR counter/keystream logic and the round datapath, and it owns the round index that selects the 128-bit round-key slice.

## Interface
- NROUNDS, 10: index of the final round; the block supports only AES-128, so the value is fixed at 10.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  expanded key schedule is stable and usable.
- in_valid  in  1  input block offered.
- in_ready  out  1  block can be accepted this cycle.
- in_block  in  128  plaintext/counter block.
- out_valid  out  1  result block available.
- out_ready  in  1  consumer accepts the result.
- out_block  out  128  result block, taken directly from the state register.
- round  out  4  round index driven to the key-XOR stage.
- sub_en  out  1  enable SubBytes+ShiftRows; low means bypass.
- mix_en  out  1  enable MixColumns; low means bypass.
- dp_state  out  128  current state register, fed to the datapath input.
- dp_result  in  128  datapath output, combinational from dp_state.
- busy  out  1  high when FSM is in RUN.
- abort  out  1  one-cycle pulse when an operation is aborted.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = key_valid.
  - On in_valid & in_ready: state_q <= in_block, rcnt <= 0, go to RUN.
- RUN:
  - round = rcnt.
  - sub_en = (rcnt != 0).
  - mix_en = (rcnt != 0) & (rcnt != 10).
  - Every cycle: state_q <= dp_result, rcnt <= rcnt + 1.
  - When rcnt == 10: go to DONE instead of incrementing.
- DONE:
  - out_valid = 1; out_block = state_q, held stable.
  - On out_ready: go to IDLE.
- Outside RUN: round = 0, sub_en = 0, mix_en = 0.
- round never exceeds 4'hA; rcnt is 4 bits and saturates at 10; it never wraps.
- Abort: if key_valid is low in any RUN cycle, go to IDLE next cycle, pulse abort for one cycle, leave state_q unchanged, and never assert out_valid for that block.
- key_valid low in DONE: the result is still delivered; no abort.
- in_valid is ignored in RUN and in DONE (except as described under Configuration).
- dp_state = state_q at all times.

## Timing
- Reset values: FSM = IDLE, rcnt = 0, state_q = 0, out_valid = 0, out_block = 0, round = 0, sub_en = 0, mix_en = 0, busy = 0, abort = 0.
- in_ready is low during any cycle in which rst is high.
- Let the accept handshake occur in cycle 0:
  - Cycles 1..11: RUN, with round = 0..10.
  - Cycle 12: out_valid = 1.
  - Latency is therefore 12 cycles.
- If out_ready is high in cycle 12, IDLE is entered in cycle 13 and the next accept can happen in cycle 13. Throughput is one block per 13 cycles.
- out_valid stays high, with out_block stable, until the cycle in which out_ready is sampled high.
- rst during RUN or DONE returns all state to its reset values on the next edge; no abort pulse is generated.
- abort is asserted in the cycle immediately after the RUN cycle in which key_valid was sampled low.

## Configuration
- Macro: AES_ROUND_CTRL_BACK2BACK_EN.
- Defined:
  - In DONE, in_ready = out_ready & key_valid.
  - A simultaneous output and input handshake loads the new block and goes directly to RUN with rcnt = 0.
  - Throughput becomes one block per 12 cycles.
- Undefined:
  - in_ready = 0 in DONE.
  - The FSM always passes through IDLE between blocks.

## Test plan
- FIPS-197 vector, using a behavioural round model: key 000102..0f, in_block 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a with out_valid in cycle 12; round sequence 0..10; sub_en low only in round 0; mix_en low in rounds 0 and 10.
- Backpressure: hold out_ready low for 20 cycles -> out_valid and out_block stay stable; in_ready stays 0 throughout; after out_ready rises, in_ready = 1 on the next cycle (macro undefined).
- key_valid low in IDLE with in_valid high -> in_ready = 0; no transition. Drop key_valid in RUN at round 5 -> abort pulses for one cycle, FSM returns to IDLE, and out_valid is never asserted.
- Assert rst mid-RUN at round 7 -> next cycle all outputs equal their reset values, busy = 0, and no abort.
- Back-to-back with macro defined: in_valid and out_ready held high, 4 blocks -> accepts spaced 12 cycles apart; each output matches the model.
- Same stimulus with macro undefined -> accepts spaced 13 cycles apart.
